// File: rtl/adder_pkg.sv
// Shared constants, chunk-width helper and per-stage register record for pipelined_adder.
// PIPELINED_ADDER_OVF_EN adds the signed-overflow flag to the stage record.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 2;
  localparam int MAX_WIDTH      = 64;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Sized for the widest supported adder; bits at and above WIDTH stay zero.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
`ifdef PIPELINED_ADDER_OVF_EN
    logic                 ovf;
`endif
    logic [MAX_WIDTH-1:0] sum;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
  } stage_reg_t;

endpackage

// File: rtl/adder_stage.sv
// One CW-bit chunk add followed by its pipeline register.
// Operands shift right and sum shifts in from the top, so every stage works on the low chunk.
module adder_stage
  import adder_pkg::*;
#(
  parameter int CW    = 4,
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  stage_reg_t i_stage,
  output stage_reg_t o_stage
);

  logic [CW:0]      w_chunk;
  logic [WIDTH-1:0] w_sum_sh;
  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic             w_unused;
  stage_reg_t       w_next;
  stage_reg_t       r_stage;

  assign w_chunk = {1'b0, i_stage.a[CW-1:0]} + {1'b0, i_stage.b[CW-1:0]}
                 + {{CW{1'b0}}, i_stage.carry};

  generate
    if (CW == WIDTH) begin : g_single
      assign w_sum_sh = w_chunk[CW-1:0];
      assign w_a_sh   = '0;
      assign w_b_sh   = '0;
    end else begin : g_multi
      assign w_sum_sh = {w_chunk[CW-1:0], i_stage.sum[WIDTH-1:CW]};
      assign w_a_sh   = {{CW{1'b0}}, i_stage.a[WIDTH-1:CW]};
      assign w_b_sh   = {{CW{1'b0}}, i_stage.b[WIDTH-1:CW]};
    end
  endgenerate

  always_comb begin
    w_next                = '0;
    w_next.valid          = i_stage.valid;
    w_next.carry          = w_chunk[CW];
    w_next.sum[WIDTH-1:0] = w_sum_sh;
    w_next.a[WIDTH-1:0]   = w_a_sh;
    w_next.b[WIDTH-1:0]   = w_b_sh;
`ifdef PIPELINED_ADDER_OVF_EN
    // Carry into the chunk MSB xor carry out; only the last stage's value survives.
    w_next.ovf = i_stage.a[CW-1] ^ i_stage.b[CW-1] ^ w_chunk[CW-1] ^ w_chunk[CW];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else if (i_en) begin
      r_stage <= w_next;
    end
  end

  assign o_stage  = r_stage;
  assign w_unused = &{1'b0, i_stage.sum, i_stage.a, i_stage.b};

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES chunks with a registered carry between them and valid/ready flow.
// PIPELINED_ADDER_OVF_EN adds the signed overflow output aligned with sum.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  generate
    if (STAGES < 1 || WIDTH < 1 || WIDTH > MAX_WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a multiple of STAGES and at most MAX_WIDTH");
    end
  endgenerate

  logic       w_en;
  logic       w_unused;
  stage_reg_t w_in;
  stage_reg_t w_last;
  stage_reg_t w_chain [STAGES];

  // The whole pipe moves together; a stalled output freezes every stage.
  assign w_en     = out_ready || !out_valid;
  assign in_ready = w_en;

  always_comb begin
    w_in                = '0;
    w_in.valid          = in_valid;
    w_in.carry          = cin;
    w_in.a[WIDTH-1:0]   = a;
    w_in.b[WIDTH-1:0]   = b;
  end

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      stage_reg_t w_src;
      if (gi == 0) begin : g_first
        assign w_src = w_in;
      end else begin : g_next
        assign w_src = w_chain[gi-1];
      end
      adder_stage #(
        .CW    (CW),
        .WIDTH (WIDTH)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_en),
        .i_stage (w_src),
        .o_stage (w_chain[gi])
      );
    end
  endgenerate

  assign w_last    = w_chain[STAGES-1];
  assign out_valid = w_last.valid;
  assign sum       = w_last.sum[WIDTH-1:0];
  assign carry     = w_last.carry;
`ifdef PIPELINED_ADDER_OVF_EN
  assign overflow  = w_last.ovf;
`endif
  assign w_unused  = &{1'b0, w_last.sum, w_last.a, w_last.b};

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: four instances (STAGES 1,2,4,8) share stimulus; each has its own queue model.
// Directed literal checks target the STAGES=2 instance; PIPELINED_ADDER_OVF_EN enables overflow checks.
module tb_pipelined_adder;

  localparam int W  = 8;
  localparam int NI = 4;
`ifdef PIPELINED_ADDER_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  typedef struct {
    exp_t e;
    int   age;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready, cin_i;
  logic [W-1:0] a_i, b_i;
  logic [NI-1:0] d_in_ready, d_out_valid, d_carry, d_ovf;
  logic [NI-1:0][W-1:0] d_sum;
  int total = 0;
  int bad = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  // Result from plain integer arithmetic; overflow from the signed range.
  function automatic exp_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t r;
    int   u, sx, sy, ss;
    u  = int'(x) + int'(y) + int'(ci);
    sx = (x >= 8'h80) ? int'(x) - 256 : int'(x);
    sy = (y >= 8'h80) ? int'(y) - 256 : int'(y);
    ss = sx + sy + int'(ci);
    r.s = u[W-1:0];
    r.c = (u >= 256);
    r.v = (ss > 127) || (ss < -128);
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int ST = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : 8;
      ent_t q[$];

      pipelined_adder #(
        .WIDTH  (W),
        .STAGES (ST)
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (d_in_ready[gi]),
        .a         (a_i),
        .b         (b_i),
        .cin       (cin_i),
        .out_valid (d_out_valid[gi]),
        .out_ready (out_ready),
        .sum       (d_sum[gi]),
        .carry     (d_carry[gi])
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .overflow  (d_ovf[gi])
`endif
      );
`ifndef PIPELINED_ADDER_OVF_EN
      assign d_ovf[gi] = 1'b0;
`endif

      // Each accepted add ages once per advancing edge; it is visible once it has aged ST.
      always @(posedge clk) begin
        bit   hv;
        ent_t n;
        hv = (q.size() > 0) && (q[0].age == ST);
        if (!rst_n) begin
          q.delete();
        end else if (out_ready || !hv) begin
          if (hv) void'(q.pop_front());
          for (int k = 0; k < q.size(); k++) q[k].age++;
          if (in_valid) begin
            n.e   = ref_add(a_i, b_i, cin_i);
            n.age = 1;
            q.push_back(n);
          end
        end
      end

      always @(negedge clk) begin
        bit hv;
        if (armed) begin
          hv = (q.size() > 0) && (q[0].age == ST);
          total++;
          if (d_out_valid[gi] !== hv || d_in_ready[gi] !== (out_ready || !hv) ||
              (hv && (d_sum[gi] !== q[0].e.s || d_carry[gi] !== q[0].e.c ||
                      (OVF && d_ovf[gi] !== q[0].e.v)))) begin
            bad++;
            $display("FAIL model st=%0d t=%0t valid=%b want=%b rdy=%b sum=%h want=%h carry=%b want=%b ovf=%b want=%b",
                     ST, $time, d_out_valid[gi], hv, d_in_ready[gi], d_sum[gi],
                     hv ? q[0].e.s : 8'h00, d_carry[gi], hv ? q[0].e.c : 1'b0,
                     d_ovf[gi], hv ? q[0].e.v : 1'b0);
          end
        end
      end
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    in_valid = 1'b1;
    a_i      = x;
    b_i      = y;
    cin_i    = ci;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic chk_out(input string name, input logic [W-1:0] s, input logic c);
    chk({name, "_valid"}, d_out_valid[1], 1);
    chk({name, "_sum"}, d_sum[1], s);
    chk({name, "_carry"}, d_carry[1], c);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_i = '0; b_i = '0; cin_i = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    armed = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("reset_valid", d_out_valid[i], 0);
      chk("reset_sum", d_sum[i], 0);
      chk("reset_ready", d_in_ready[i], 1);
    end
    chk("reset_carry", d_carry[1], 0);
    chk("reset_ovf", d_ovf[1], 0);

    // Carry crosses the chunk boundary.
    xfer(8'h0F, 8'h01, 1'b0);
    step();
    chk_out("cross", 8'h10, 1'b0);
    idle(10);

    xfer(8'hFF, 8'h00, 1'b1);
    xfer(8'hAA, 8'h55, 1'b0);
    chk_out("ff_cin", 8'h00, 1'b1);
    step();
    chk_out("aa55", 8'hFF, 1'b0);
    idle(10);

    xfer(8'h01, 8'h01, 1'b0);
    xfer(8'h02, 8'h02, 1'b0);
    chk_out("b2b0", 8'h02, 1'b0);
    xfer(8'h03, 8'h03, 1'b0);
    chk_out("b2b1", 8'h04, 1'b0);
    xfer(8'h80, 8'h80, 1'b0);
    chk_out("b2b2", 8'h06, 1'b0);
    step();
    chk_out("b2b3", 8'h00, 1'b1);
    idle(10);

    // Backpressure: hold three cycles with a new input waiting.
    xfer(8'h10, 8'h20, 1'b0);
    xfer(8'h30, 8'h40, 1'b1);
    chk_out("pre_stall", 8'h30, 1'b0);
    in_valid = 1'b1; a_i = 8'h50; b_i = 8'h60; cin_i = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("stall_in_ready", d_in_ready[1], 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall_hold", 8'h30, 1'b0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk_out("release0", 8'h71, 1'b0);
    step();
    chk_out("release1", 8'hB0, 1'b0);
    idle(10);

    // Reset with two adds in flight and a transfer offered in the reset cycle.
    xfer(8'h01, 8'h02, 1'b0);
    xfer(8'h03, 8'h04, 1'b0);
    rst_n = 1'b0; in_valid = 1'b1; a_i = 8'h77; b_i = 8'h11;
    step();
    for (int i = 0; i < NI; i++) begin
      chk("midrst_valid", d_out_valid[i], 0);
      chk("midrst_sum", d_sum[i], 0);
      chk("midrst_carry", d_carry[i], 0);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    step();
    chk("midrst_stale", d_out_valid[1], 0);
    idle(10);

    xfer(8'h7F, 8'h01, 1'b0);
    step();
    chk_out("ovf_pos", 8'h80, 1'b0);
    if (OVF) chk("ovf_pos_flag", d_ovf[1], 1);
    xfer(8'hFF, 8'h01, 1'b0);
    step();
    chk_out("ovf_neg1", 8'h00, 1'b1);
    if (OVF) chk("ovf_neg1_flag", d_ovf[1], 0);
    idle(10);

    // Mixed traffic and backpressure, checked by the per-instance models.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a_i       = W'($urandom);
      b_i       = W'($urandom);
      cin_i     = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    out_ready = 1'b1;
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the team's 2-bit full adder: adds two WIDTH-bit operands plus carry-in and returns sum and carry-out. The operands are split into STAGES equal chunks, with the carry registered between stages. A valid/ready handshake with backpressure allows one add per cycle in the datapath's arithmetic blocks, where a single-cycle ripple adder cannot close timing.

## Interface
- WIDTH, 8, operand/sum width in bits (≥1)
- STAGES, 2, pipeline stages; WIDTH % STAGES == 0 required (elaboration error otherwise); chunk width CW = WIDTH/STAGES
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset; synchronous and active-low
- in_valid  input  1  a, b, cin valid this cycle
- in_ready  output  1  block accepts the input this cycle
- a  input  WIDTH  operand A, unsigned (two's complement when overflow enabled)
- b  input  WIDTH  operand B
- cin  input  1  carry-in into bit 0
- out_valid  output  1  sum/carry hold a result
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
- carry  output  1  bit WIDTH of a + b + cin
- overflow  output  1  signed overflow; present only with PIPELINED_ADDER_OVF_EN

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
- Stage k (0..STAGES-1) computes chunk k: {c_k+1, s_k} = a[k] + b[k] + c_k, with c_0 = cin. All terms are CW+1 bits wide; no truncation until the chunk sum is split.
- Unconsumed upper operand chunks and completed lower sum chunks travel with the transaction through per-stage registers.
- Each stage has a valid bit. Global advance enable: en = out_ready || !out_valid. in_ready = en, so it is combinationally dependent on out_ready.
- When en = 1, every stage register loads from its predecessor and stage 0 loads from the inputs. Stage-0 valid ← in_valid.
- When en = 0, all stages hold. sum, carry and overflow stay stable while out_valid && !out_ready.
- Transactions leave in order; none is dropped or duplicated. Internal bubbles are carried through and are not compressed.
- STAGES = 1 gives a single registered full-width adder.
- Reset values (rst_n = 0 at an edge): all valid bits 0, out_valid 0, sum 0, carry 0, overflow 0. in_ready = 1 in the cycle after reset.
- Reset mid-operation discards every in-flight transaction. A transfer presented in the reset cycle is not accepted.

## Timing
- Latency: a transfer accepted at edge N appears with out_valid = 1 after edge N+STAGES-1, provided there is no stall. A stall of S cycles adds S.
- Throughput: one result per cycle while out_ready = 1.
- A simultaneous input and output transfer is allowed and is the steady state.
- Combinational path: out_ready to in_ready only. The carry path is CW bits per cycle.

## Configuration
- PIPELINED_ADDER_OVF_EN defined: the overflow port exists and is aligned with sum. Its value is the carry into bit WIDTH-1 XOR carry; this is correct for signed add with cin.
- Undefined: no overflow port and no extra flops. All other behaviour is identical.

## Structure
- Package adder_pkg: default WIDTH/STAGES constants, a chunk-width function, and a stage-register struct typedef (valid, carry, partial sum, remaining operands).
- Sub-module adder_stage (params CW, WIDTH): one chunk add plus its pipeline register with enable and reset. The top instantiates STAGES copies in a generate loop.

## Test plan
- WIDTH=8, STAGES=2, out_ready=1; a=0x0F, b=0x01, cin=0 → 2 cycles later sum=0x10, carry=0 (carry crosses the chunk boundary).
- a=0xFF, b=0x00, cin=1 → sum=0x00, carry=1; then a=0xAA, b=0x55, cin=0 → sum=0xFF, carry=0.
- Four back-to-back transfers (0x01+0x01, 0x02+0x02, 0x03+0x03, 0x80+0x80) → out_valid high 4 consecutive cycles with 0x02, 0x04, 0x06, 0x00/carry=1, in order.
- out_ready held low 3 cycles while out_valid=1 → in_ready=0, sum/carry unchanged, no input accepted. On release, results resume in order with no loss.
- rst_n low for one cycle with 2 transactions in flight → out_valid=0, sum=0, carry=0 after that edge, and no stale result afterwards.
- With PIPELINED_ADDER_OVF_EN: 0x7F+0x01 → sum=0x80, overflow=1; 0xFF+0x01 → sum=0x00, carry=1, overflow=0. Repeat the whole suite with STAGES=1, 4, 8.
